// File: rtl/commit_return_queue_if.sv
// Rename/commit-side bundle of the commit return queue.
// Master drives allocations, commits and flushes; slave is the queue itself.
interface commit_return_queue_if #(
  parameter int NUM_D_REG = 32,
  parameter int NUM_S_REG = 8,
  parameter int DEPTH     = 16
);
  localparam int RW = $clog2(NUM_D_REG);
  localparam int SW = $clog2(NUM_S_REG);
  localparam int CW = $clog2(DEPTH + 1);

  logic                 alloc_valid;
  logic                 alloc_use_rw;
  logic                 alloc_use_rs;
  logic [RW-1:0]        alloc_old_rw;
  logic [RW-1:0]        alloc_new_rw;
  logic [SW-1:0]        alloc_old_rs;
  logic [SW-1:0]        alloc_new_rs;
  logic                 alloc_ready;
  logic                 commit_valid;
  logic                 flush;
  logic [NUM_D_REG-1:0] return_r_list;
  logic [NUM_S_REG-1:0] return_s_list;
  logic [CW-1:0]        count;
  logic                 empty;

  modport master (
    output alloc_valid, alloc_use_rw, alloc_use_rs, alloc_old_rw, alloc_new_rw,
           alloc_old_rs, alloc_new_rs, commit_valid, flush,
    input  alloc_ready, return_r_list, return_s_list, count, empty
  );

  modport slave (
    input  alloc_valid, alloc_use_rw, alloc_use_rs, alloc_old_rw, alloc_new_rw,
           alloc_old_rs, alloc_new_rs, commit_valid, flush,
    output alloc_ready, return_r_list, return_s_list, count, empty
  );
endinterface

// File: rtl/commit_return_queue.sv
// In-order queue of rename allocations; commit returns old mappings, flush returns new ones.
// Return masks are registered one-cycle pulses; alloc_ready drops when full, excess pushes are ignored.
module commit_return_queue #(
  parameter int NUM_D_REG = 32,
  parameter int NUM_S_REG = 8,
  parameter int DEPTH     = 16
) (
  input logic                   clk,
  input logic                   rst,
  commit_return_queue_if.slave  bus
);
  localparam int RW = $clog2(NUM_D_REG);
  localparam int SW = $clog2(NUM_S_REG);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic          use_rw_q [DEPTH];
  logic          use_rs_q [DEPTH];
  logic [RW-1:0] old_rw_q [DEPTH];
  logic [RW-1:0] new_rw_q [DEPTH];
  logic [SW-1:0] old_rs_q [DEPTH];
  logic [SW-1:0] new_rs_q [DEPTH];

  logic [PW-1:0]        head;
  logic [PW-1:0]        tail;
  logic [CW-1:0]        count_q;
  logic [NUM_D_REG-1:0] ret_r_q;
  logic [NUM_S_REG-1:0] ret_s_q;

  logic                 push;
  logic                 pop;
  logic [PW-1:0]        slot_off [DEPTH];
  logic [NUM_D_REG-1:0] r_mask;
  logic [NUM_S_REG-1:0] s_mask;

  assign bus.alloc_ready   = (count_q != CW'(DEPTH));
  assign bus.empty         = (count_q == '0);
  assign bus.count         = count_q;
  assign bus.return_r_list = ret_r_q;
  assign bus.return_s_list = ret_s_q;

  assign push = bus.alloc_valid & bus.alloc_ready & ~bus.flush;
  assign pop  = bus.commit_valid & ~bus.empty;

  // Age of each slot relative to head; a slot is in flight when its age is below count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_off[i] = PW'(i) - head;
    end
  end

  always_comb begin
    r_mask = '0;
    s_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (pop && (PW'(i) == head)) begin
        if (use_rw_q[i]) r_mask[old_rw_q[i]] = 1'b1;
        if (use_rs_q[i]) s_mask[old_rs_q[i]] = 1'b1;
      end else if (bus.flush && (CW'(slot_off[i]) < count_q)) begin
        if (use_rw_q[i]) r_mask[new_rw_q[i]] = 1'b1;
        if (use_rs_q[i]) s_mask[new_rs_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      use_rw_q[tail] <= bus.alloc_use_rw;
      use_rs_q[tail] <= bus.alloc_use_rs;
      old_rw_q[tail] <= bus.alloc_old_rw;
      new_rw_q[tail] <= bus.alloc_new_rw;
      old_rs_q[tail] <= bus.alloc_old_rs;
      new_rs_q[tail] <= bus.alloc_new_rs;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      ret_r_q <= '0;
      ret_s_q <= '0;
    end else begin
      ret_r_q <= r_mask;
      ret_s_q <= s_mask;
      if (bus.flush) begin
        head    <= '0;
        tail    <= '0;
        count_q <= '0;
      end else begin
        if (push) tail <= tail + PW'(1);
        if (pop)  head <= head + PW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end
endmodule
